mem_arbiter: RTL and testbench

Two-port arbiter that shares the single external memory bus between the Beta instruction fetch path and the data (load/store) path. It latches one request at a time, drives a registered memory transaction, waits for the memory's ready handshake, returns read data to the winning requester with a one-cycle done pulse, and aborts stalled accesses with a watchdog. It sits between the core (`ia`/`id` and `memAddr`/`memWriteData`/`MemRead`/`MemWrite`) and the memory/cache.

---
 rtl/mem_arbiter.sv | 111 +++++++++++
 tb/tb_mem_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory bus between fetch and data ports with a timeout watchdog.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise data wins ties.
module mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ready,
  output logic        owner,
  output logic        busy,
  output logic        err
);
  localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2;
  localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES - 1);
  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d, owner_q, owner_d, m_we_q, m_we_d, gnt, fin;
  logic [31:0] m_addr_q, m_addr_d, m_wdata_q, m_wdata_d, i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic [31:0] cap;
`ifdef MEM_ARB_RR_EN
  logic last_q, last_d;
  assign gnt = d_req & (~i_req | ~last_q);
  assign last_d = (state_q == IDLE && (i_req || d_req)) ? gnt : last_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) last_q <= 1'b0;
    else last_q <= last_d;
`else
  assign gnt = d_req;
`endif
  // A timeout completes with zero data; m_ready on the limit edge still wins.
  assign fin = m_ready || cnt_q == LIMIT;
  assign cap = m_ready ? m_rdata : 32'h0;
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    owner_d   = owner_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    if (state_q == IDLE) begin
      if (i_req || d_req) begin
        state_d   = ACCESS;
        cnt_d     = 8'd0;
        err_d     = 1'b0;
        owner_d   = gnt;
        m_we_d    = gnt & d_we;
        m_addr_d  = gnt ? d_addr : i_addr;
        m_wdata_d = gnt ? d_wdata : 32'h0;
      end
    end else if (state_q == ACCESS) begin
      state_d   = fin ? DONE : ACCESS;
      cnt_d     = fin ? cnt_q : cnt_q + 8'd1;
      err_d     = fin & ~m_ready;
      i_rdata_d = (fin && !owner_q) ? cap : i_rdata_q;
      d_rdata_d = (fin && owner_q) ? cap : d_rdata_q;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      err_q     <= 1'b0;
      owner_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= 32'h0;
      m_wdata_q <= 32'h0;
      i_rdata_q <= 32'h0;
      d_rdata_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      owner_q   <= owner_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  assign m_req   = state_q == ACCESS;
  assign busy    = state_q != IDLE;
  assign owner   = owner_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign i_done  = state_q == DONE && !owner_q;
  assign d_done  = state_q == DONE && owner_q;
  assign err     = state_q == DONE && err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter with TIMEOUT_CYCLES=8.
module tb_mem_arbiter;
  logic        clk = 1'b0, reset = 1'b0;
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, m_ready = 1'b0;
  logic [31:0] i_addr = 32'h0, d_addr = 32'h0, d_wdata = 32'h0, m_rdata = 32'h0;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic        i_done, d_done, m_req, m_we, owner, busy, err;
  int checks = 0, errors = 0;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  mem_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_done(d_done),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ready(m_ready),
    .owner(owner), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({m_req, m_we, i_done, d_done, err, busy, owner} !== 7'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 0000000", {m_req, m_we, i_done, d_done, err, busy, owner});
    end
    checks++;
    if ({m_addr, m_wdata, i_rdata, d_rdata} !== 128'h0) begin
      errors++; $display("FAIL reset_data got %h %h %h %h want zeros", m_addr, m_wdata, i_rdata, d_rdata);
    end
    reset = 1'b1;
  endtask

  task automatic test_fetch();
    i_req = 1'b1; i_addr = 32'h100;
    @(negedge clk);
    i_req = 1'b0;
    checks++;
    if ({m_req, m_we, owner, busy, m_addr} !== {4'b1001, 32'h100}) begin
      errors++; $display("FAIL fetch_access got req=%b we=%b own=%b busy=%b addr=%h want 1 0 0 1 100", m_req, m_we, owner, busy, m_addr);
    end
    m_ready = 1'b1; m_rdata = 32'hA5A5_0001;
    @(negedge clk);
    m_ready = 1'b0;
    checks++;
    if ({i_done, d_done, err, m_req, i_rdata} !== {4'b1000, 32'hA5A5_0001}) begin
      errors++; $display("FAIL fetch_done got id=%b dd=%b err=%b mreq=%b rdata=%h want 1 0 0 0 a5a50001", i_done, d_done, err, m_req, i_rdata);
    end
    @(negedge clk);
    checks++;
    if ({i_done, busy} !== 2'b00) begin
      errors++; $display("FAIL fetch_idle got id=%b busy=%b want 0 0", i_done, busy);
    end
  endtask

  task automatic test_store_wait();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'h1234_5678;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) begin d_req = 1'b0; d_we = 1'b0; d_wdata = 32'h0; end
      checks++;
      if ({m_req, m_we, owner, m_addr, m_wdata} !== {3'b111, 32'h2000, 32'h1234_5678}) begin
        errors++; $display("FAIL store_hold c=%0d got req=%b we=%b own=%b addr=%h wdata=%h want 1 1 1 2000 12345678", c, m_req, m_we, owner, m_addr, m_wdata);
      end
      if (c == 4) begin m_ready = 1'b1; m_rdata = 32'hDEAD_BEEF; end
    end
    @(negedge clk);
    m_ready = 1'b0;
    checks++;
    if ({d_done, i_done, err, i_rdata, d_rdata} !== {3'b100, 32'hA5A5_0001, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL store_done got dd=%b id=%b err=%b ir=%h dr=%h want 1 0 0 a5a50001 deadbeef", d_done, i_done, err, i_rdata, d_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_arbitration();
    logic exp;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; i_addr = 32'h0111; d_addr = 32'h0D00;
    for (int k = 0; k < 4; k++) begin
      exp = RR ? (k % 2 == 0) : 1'b1;
      @(negedge clk);
      checks++;
      if ({owner, busy, m_addr} !== {exp, 1'b1, exp ? 32'h0D00 : 32'h0111}) begin
        errors++; $display("FAIL arb_owner k=%0d got own=%b busy=%b addr=%h want own=%b", k, owner, busy, m_addr, exp);
      end
      m_ready = 1'b1; m_rdata = 32'hC0DE_0000 | k;
      @(negedge clk);
      m_ready = 1'b0;
      checks++;
      if ({i_done, d_done} !== {~exp, exp}) begin
        errors++; $display("FAIL arb_done k=%0d got id=%b dd=%b want %b %b", k, i_done, d_done, ~exp, exp);
      end
      @(negedge clk);
      if (k == 3) begin i_req = 1'b0; d_req = 1'b0; end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL arb_release got busy=%b want 0", busy);
    end
  endtask

  task automatic test_timeout();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) d_req = 1'b0;
      checks++;
      if ({m_req, err, d_done} !== 3'b100) begin
        errors++; $display("FAIL timeout_wait c=%0d got req=%b err=%b dd=%b want 1 0 0", c, m_req, err, d_done);
      end
    end
    @(negedge clk);
    checks++;
    if ({d_done, err, busy, m_req, d_rdata} !== {4'b1110, 32'h0}) begin
      errors++; $display("FAIL timeout_done got dd=%b err=%b busy=%b mreq=%b dr=%h want 1 1 1 0 0", d_done, err, busy, m_req, d_rdata);
    end
    @(negedge clk);
    checks++;
    if ({busy, err, d_done} !== 3'b000) begin
      errors++; $display("FAIL timeout_idle got busy=%b err=%b dd=%b want 0 0 0", busy, err, d_done);
    end
  endtask

  task automatic test_timeout_edge();
    i_req = 1'b1; i_addr = 32'h500;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) i_req = 1'b0;
      if (c == 8) begin
        checks++;
        if (m_req !== 1'b1) begin
          errors++; $display("FAIL edge_access got mreq=%b want 1", m_req);
        end
        m_ready = 1'b1; m_rdata = 32'h5EED_0008;
      end
    end
    @(negedge clk);
    m_ready = 1'b0;
    checks++;
    if ({i_done, err, i_rdata, d_rdata} !== {2'b10, 32'h5EED_0008, 32'h0}) begin
      errors++; $display("FAIL edge_done got id=%b err=%b ir=%h dr=%h want 1 0 5eed0008 0", i_done, err, i_rdata, d_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    i_req = 1'b1; i_addr = 32'h300;
    @(negedge clk);
    i_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({m_req, m_addr} !== {1'b1, 32'h300}) begin
      errors++; $display("FAIL mid_access got mreq=%b addr=%h want 1 300", m_req, m_addr);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({m_req, m_we, i_done, d_done, err, busy, owner, m_addr, i_rdata, d_rdata} !== 103'h0) begin
      errors++; $display("FAIL mid_async got mreq=%b busy=%b addr=%h ir=%h dr=%h want zeros", m_req, busy, m_addr, i_rdata, d_rdata);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({i_done, d_done, busy} !== 3'b000) begin
      errors++; $display("FAIL mid_nodone got id=%b dd=%b busy=%b want 0 0 0", i_done, d_done, busy);
    end
    i_req = 1'b1; i_addr = 32'h304;
    @(negedge clk);
    i_req = 1'b0;
    checks++;
    if ({m_req, owner, m_addr} !== {2'b10, 32'h304}) begin
      errors++; $display("FAIL mid_new_access got mreq=%b own=%b addr=%h want 1 0 304", m_req, owner, m_addr);
    end
    m_ready = 1'b1; m_rdata = 32'h7777_0304;
    @(negedge clk);
    m_ready = 1'b0;
    checks++;
    if ({i_done, err, i_rdata} !== {2'b10, 32'h7777_0304}) begin
      errors++; $display("FAIL mid_new_done got id=%b err=%b ir=%h want 1 0 77770304", i_done, err, i_rdata);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store_wait();
    test_arbitration();
    test_timeout();
    test_timeout_edge();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
